// File: rtl/membank_pkg.sv
// Shared definitions for the 64x16 node memory bank and its sequencers.
// Word/depth/index widths and the reader FSM state encoding.
package membank_pkg;

  localparam int WORD_WIDTH = 16;
  localparam int MEM_DEPTH  = 64;
  localparam int IDX_W      = $clog2(MEM_DEPTH);
  localparam int PTR_W      = IDX_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    PRESENT,
    DONE
  } rd_state_e;

endpackage

// File: rtl/membank_max_tracker.sv
// Running unsigned maximum over handshaken bank entries.
// Ports: clk, nrst, clear, update, data, index in; max_data, max_index out.
module membank_max_tracker
  import membank_pkg::*;
(
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  clear,
  input  logic                  update,
  input  logic [WORD_WIDTH-1:0] data,
  input  logic [IDX_W-1:0]      index,
  output logic [WORD_WIDTH-1:0] max_data,
  output logic [IDX_W-1:0]      max_index
);

  // Strict compare: on ties the earlier (lower) index is kept.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      max_data  <= '0;
      max_index <= '0;
    end else if (clear) begin
      max_data  <= '0;
      max_index <= '0;
    end else if (update && (data > max_data)) begin
      max_data  <= data;
      max_index <= index;
    end
  end

endmodule

// File: rtl/membank_reader.sv
// Read-side sequencer: scans bank entries 0..n-1 onto a valid/ready stream.
// Ports: clk, nrst, start, abort, count[6:0] in; busy, done out;
//   mem_index[5:0], mem_wr_en out, mem_data_in[15:0] in;
//   out_data[15:0], out_index[5:0], out_valid, out_last out, out_ready in.
//   MEMBANK_READER_MAX_EN adds max_data[15:0], max_index[5:0], max_valid.
module membank_reader
  import membank_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [PTR_W-1:0]      count,
  output logic                  busy,
  output logic                  done,
  output logic [IDX_W-1:0]      mem_index,
  output logic                  mem_wr_en,
  input  logic [WORD_WIDTH-1:0] mem_data_in,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic [IDX_W-1:0]      out_index,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
`ifdef MEMBANK_READER_MAX_EN
  ,
  output logic [WORD_WIDTH-1:0] max_data,
  output logic [IDX_W-1:0]      max_index,
  output logic                  max_valid
`endif
);

  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(MEM_DEPTH);
  localparam logic [1:0]       LAT_P   = 2'(RD_LAT);

  rd_state_e        state;
  rd_state_e        state_nxt;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] n;
  logic [1:0]       wcnt;
  logic             go;
  logic             cap;
  logic             hs;

  assign done      = (state == DONE);
  assign mem_wr_en = 1'b0;
  // ptr only moves when entering ISSUE, so the address holds elsewhere.
  assign mem_index = ptr[IDX_W-1:0];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    cap       = 1'b0;
    hs        = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (count == '0) begin
            state_nxt = DONE;
          end else begin
            go        = 1'b1;
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (wcnt == 2'd1) begin
          cap       = 1'b1;
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          hs        = 1'b1;
          state_nxt = out_last ? DONE : ISSUE;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt = IDLE;
      go        = 1'b0;
      cap       = 1'b0;
      hs        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ptr       <= '0;
      n         <= '0;
      wcnt      <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
    end else if (abort) begin
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (go) begin
        n    <= (count > DEPTH_P) ? DEPTH_P : count;
        ptr  <= '0;
        busy <= 1'b1;
      end
      if (state == ISSUE) wcnt <= LAT_P;
      if (state == WAIT)  wcnt <= wcnt - 2'd1;
      if (cap) begin
        out_data  <= mem_data_in;
        out_index <= ptr[IDX_W-1:0];
        out_last  <= (ptr == n - PTR_W'(1));
        out_valid <= 1'b1;
      end
      if (hs) begin
        out_valid <= 1'b0;
        if (!out_last) ptr <= ptr + PTR_W'(1);
      end
      if (state == DONE) busy <= 1'b0;
    end
  end

`ifdef MEMBANK_READER_MAX_EN
  logic trk_clr;

  assign trk_clr = abort | ((state == IDLE) & start);

  membank_max_tracker u_max (
    .clk       (clk),
    .nrst      (nrst),
    .clear     (trk_clr),
    .update    (hs),
    .data      (out_data),
    .index     (out_index),
    .max_data  (max_data),
    .max_index (max_index)
  );

  // Rises on the final handshake so it is visible alongside done.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)              max_valid <= 1'b0;
    else if (trk_clr)       max_valid <= 1'b0;
    else if (hs && out_last) max_valid <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_membank_reader.sv
// Scoreboard bench for membank_reader with a 1-cycle bank model.
// Expected entries are queued at start; a negedge monitor checks them.
module tb_membank_reader;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [6:0]  count = '0;
  logic        busy;
  logic        done;
  logic [5:0]  mem_index;
  logic        mem_wr_en;
  logic [15:0] mem_data_in = '0;
  logic [15:0] out_data;
  logic [5:0]  out_index;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;
`ifdef MEMBANK_READER_MAX_EN
  logic [15:0] max_data;
  logic [5:0]  max_index;
  logic        max_valid;
`endif

  membank_reader #(.RD_LAT(1)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .start       (start),
    .abort       (abort),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .mem_index   (mem_index),
    .mem_wr_en   (mem_wr_en),
    .mem_data_in (mem_data_in),
    .out_data    (out_data),
    .out_index   (out_index),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last)
`ifdef MEMBANK_READER_MAX_EN
    ,
    .max_data    (max_data),
    .max_index   (max_index),
    .max_valid   (max_valid)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  idx;
    logic [15:0] data;
    logic        last;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  logic [15:0] mem [64];
  int          hs_cyc[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          last_done_cyc = 0;
  int          xfer = 0;
  int          busy_hi = 0;
  int          vld_hi = 0;
  bit          rdy_rand = 1'b0;
  bit          stall_prev = 1'b0;
  logic [22:0] held;
  logic [15:0] exp_max;
  logic [5:0]  exp_maxi;

  // Bank model: registered read, one cycle after the address changes.
  always @(posedge clk) begin
    cyc         <= cyc + 1;
    mem_data_in <= mem[mem_index];
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (nrst) begin
      if (busy) busy_hi++;
      if (out_valid) vld_hi++;
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
      if (out_valid) begin
        if (stall_prev)
          check("stable", {out_index, out_data, out_last}, held);
        if (out_ready) begin
          xfer++;
          hs_cyc.push_back(cyc);
          check("xfer_expected", q.size() != 0, 1);
          if (q.size() != 0) begin
            mon_e = q.pop_front();
            check("out_index", out_index, mon_e.idx);
            check("out_data", out_data, mon_e.data);
            check("out_last", out_last, mon_e.last);
          end
          stall_prev = 1'b0;
        end else begin
          stall_prev = 1'b1;
          held = {out_index, out_data, out_last};
        end
      end else begin
        stall_prev = 1'b0;
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic start_scan(input int c);
    int nn;
    nn = (c > 64) ? 64 : c;
    exp_max  = '0;
    exp_maxi = '0;
    for (int i = 0; i < nn; i++) begin
      q.push_back(exp_t'{idx: 6'(i), data: mem[i], last: (i == nn - 1)});
      if (mem[i] > exp_max) begin
        exp_max  = mem[i];
        exp_maxi = 6'(i);
      end
    end
    start = 1'b1;
    count = 7'(c);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 4000 && done_cnt == d0; i++) tick();
    check("done_seen", done_cnt != d0, 1);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 50 && !out_valid; i++) tick();
    check("valid_seen", out_valid, 1);
  endtask

  task automatic run_scan(input int c, input bit rnd, output int k);
    int nn, x0, b0, v0, d0;
    nn = (c > 64) ? 64 : c;
    x0 = xfer;
    b0 = busy_hi;
    v0 = vld_hi;
    d0 = done_cnt;
    hs_cyc.delete();
    rdy_rand = rnd;
    if (!rnd) out_ready = 1'b1;
    k = cyc;
    start_scan(c);
    wait_done(d0);
    repeat (3) tick();
    check("done_once", done_cnt - d0, 1);
    check("queue_empty", q.size(), 0);
    check("xfer_count", xfer - x0, nn);
    check("busy_after", busy, 0);
    if (nn == 0) begin
      check("zero_busy", busy_hi - b0, 0);
      check("zero_valid", vld_hi - v0, 0);
      check("zero_done_lat", last_done_cyc - k, 1);
    end
`ifdef MEMBANK_READER_MAX_EN
    check("max_valid", max_valid, nn != 0);
    if (nn != 0) begin
      check("max_data", max_data, exp_max);
      check("max_index", max_index, exp_maxi);
    end
`endif
    rdy_rand  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int k, d0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", out_valid, 0);
    check("rst_outs", {out_last, out_data, out_index}, 0);
    check("rst_mem", {mem_index, mem_wr_en}, 0);
    nrst = 1'b1;
    tick();

    // Directed preload, full-rate consumer.
    mem[0] = 16'd3;
    mem[1] = 16'd15;
    mem[2] = 16'd7;
    mem[3] = 16'd15;
    run_scan(4, 1'b0, k);
    check("hs_count", hs_cyc.size(), 4);
    for (int i = 0; i < hs_cyc.size(); i++)
      check("hs_timing", hs_cyc[i] - k, 3 * (i + 1));

    // Back-pressure on index 1.
    d0 = done_cnt;
    out_ready = 1'b0;
    start_scan(4);
    wait_valid();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    wait_valid();
    repeat (5) begin
      check("stall_index", out_index, 1);
      check("stall_data", out_data, mem[1]);
      check("stall_wr_en", mem_wr_en, 0);
      tick();
    end
    out_ready = 1'b1;
    wait_done(d0);
    tick();
    check("stall_queue", q.size(), 0);

    // Empty scan.
    run_scan(0, 1'b0, k);

    // Clamped scan.
    for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
    mem[63] = 16'hBEEF;
    run_scan(100, 1'b0, k);

    // Reset while presenting index 2.
    start_scan(4);
    for (int i = 0; i < 50 && !(out_valid && out_index == 2); i++) tick();
    check("idx2_seen", out_valid && out_index == 2, 1);
    out_ready = 1'b0;
    nrst = 1'b0;
    tick();
    check("mid_rst_flags", {busy, done, out_valid, out_last}, 0);
    check("mid_rst_data", {out_data, out_index}, 0);
    check("mid_rst_mem", {mem_index, mem_wr_en}, 0);
    q.delete();
    nrst = 1'b1;
    out_ready = 1'b1;
    tick();
    run_scan(3, 1'b0, k);

    // Abort in WAIT of index 1, with an ignored start while busy.
    d0 = done_cnt;
    start_scan(4);
    tick();
    start = 1'b1;
    count = 7'd7;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("abort_mem_index", mem_index, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_pending", q.size(), 3);
    q.delete();
    repeat (6) tick();
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_idle_valid", out_valid, 0);
`ifdef MEMBANK_READER_MAX_EN
    check("abort_max_valid", max_valid, 0);
`endif

    // start and abort together in IDLE.
    d0 = done_cnt;
    k = vld_hi;
    start = 1'b1;
    abort = 1'b1;
    count = 7'd5;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("sa_busy", busy, 0);
    repeat (5) tick();
    check("sa_no_done", done_cnt - d0, 0);
    check("sa_no_valid", vld_hi - k, 0);

    // Random scans with random back-pressure.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 64; i++) mem[i] = 16'($urandom_range(0, 40));
      run_scan(int'($urandom_range(0, 100)), 1'b1, k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
